// File: rtl/fsm_pkg.sv
// Shared definitions for the table-driven sequencer: default widths and
// the controller mode encoding seen on the mode output.
package fsm_pkg;

    localparam int unsigned ST_W_DEF  = 3;
    localparam int unsigned SYM_W_DEF = 2;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_ERR  = 2'b10
    } mode_e;

endpackage

// File: rtl/fsm_table_ctrl_if.sv
// Configuration, symbol-stream and status signals of fsm_table_ctrl.
// master drives configuration/control/symbols, slave is the controller.
interface fsm_table_ctrl_if
    import fsm_pkg::*;
#(
    parameter int unsigned ST_W  = ST_W_DEF,
    parameter int unsigned SYM_W = SYM_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic                    cfg_we;
    logic [ST_W+SYM_W-1:0]   cfg_addr;
    logic [2*ST_W-1:0]       cfg_data;
    logic                    start;
    logic                    stop;
    logic                    sym_valid;
    logic [SYM_W-1:0]        sym;
    logic                    sym_ready;
    logic [ST_W-1:0]         saida;
    logic                    saida_valid;
    logic [1:0]              mode;
    logic [CNT_W-1:0]        sym_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop, sym_valid, sym,
        input  sym_ready, saida, saida_valid, mode, sym_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop, sym_valid, sym,
        output sym_ready, saida, saida_valid, mode, sym_cnt
    );

endinterface

// File: rtl/fsm_table.sv
// Transition table storage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fsm_table #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    // Table write on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_table_ctrl.sv
// Table-driven state sequencer. In IDLE the table is loaded and every
// written entry is tracked in a mask; start enters RUN only when the whole
// table has been written. In RUN each accepted symbol looks up
// {state,symbol}, producing the next state and a registered output pulse.
module fsm_table_ctrl
    import fsm_pkg::*;
#(
    parameter int unsigned ST_W  = ST_W_DEF,
    parameter int unsigned SYM_W = SYM_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    fsm_table_ctrl_if.slave  bus
);

    localparam int unsigned AW    = ST_W + SYM_W;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned DW    = 2 * ST_W;

    mode_e              mode_q, mode_d;
    logic [ST_W-1:0]    state_q, state_d;
    logic [ST_W-1:0]    saida_q, saida_d;
    logic               saida_valid_q, saida_valid_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [DEPTH-1:0]   mask_q, mask_d;

    logic               sym_ready;
    logic               accept;
    logic               tbl_we;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;

    // stop has priority over everything, so it blocks acceptance directly.
    assign sym_ready = (mode_q == MODE_RUN) && !bus.stop;
    assign accept    = sym_ready && bus.sym_valid;
    assign rd_addr   = {state_q, bus.sym};
    assign tbl_we    = (mode_q == MODE_IDLE) && bus.cfg_we;

    fsm_table #(
        .AW (AW),
        .DW (DW)
    ) u_table (
        .clk_i   (clk),
        .we_i    (tbl_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Controller, machine state, output, counter and mask registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= MODE_IDLE;
            state_q       <= '0;
            saida_q       <= '0;
            saida_valid_q <= 1'b0;
            sym_cnt_q     <= '0;
            mask_q        <= '0;
        end else begin
            mode_q        <= mode_d;
            state_q       <= state_d;
            saida_q       <= saida_d;
            saida_valid_q <= saida_valid_d;
            sym_cnt_q     <= sym_cnt_d;
            mask_q        <= mask_d;
        end
    end

    // Mode transitions, symbol lookup and bookkeeping.
    always_comb begin
        mode_d        = mode_q;
        state_d       = state_q;
        saida_d       = saida_q;
        saida_valid_d = 1'b0;
        sym_cnt_d     = sym_cnt_q;
        mask_d        = mask_q;

        unique case (mode_q)
            MODE_IDLE: begin
                if (bus.cfg_we) begin
                    mask_d[bus.cfg_addr] = 1'b1;
                end
                // Completeness is judged on the mask before this cycle's write.
                if (bus.start) begin
                    if (&mask_q) begin
                        mode_d    = MODE_RUN;
                        state_d   = '0;
                        sym_cnt_d = '0;
                    end else begin
                        mode_d = MODE_ERR;
                    end
                end
            end
            MODE_RUN: begin
                if (bus.stop) begin
                    mode_d  = MODE_IDLE;
                    state_d = '0;
                end else begin
                    // A symbol offered alongside an illegal write is still
                    // honoured because sym_ready was high this cycle.
                    if (accept) begin
                        state_d       = rd_data[DW-1:ST_W];
                        saida_d       = rd_data[ST_W-1:0];
                        saida_valid_d = 1'b1;
                        if (sym_cnt_q != '1) begin
                            sym_cnt_d = sym_cnt_q + 1'b1;
                        end
                    end
                    if (bus.cfg_we) begin
                        mode_d = MODE_ERR;
                    end
                end
            end
            MODE_ERR: begin
                if (bus.stop) begin
                    mode_d = MODE_IDLE;
                    mask_d = '0;
                end
            end
            default: begin
                mode_d = MODE_IDLE;
            end
        endcase
    end

    assign bus.sym_ready   = sym_ready;
    assign bus.saida       = saida_q;
    assign bus.saida_valid = saida_valid_q;
    assign bus.mode        = mode_q;
    assign bus.sym_cnt     = sym_cnt_q;

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Randomised scoreboard bench for fsm_table_ctrl.
module tb_fsm_table_ctrl;

    localparam int ST_W  = 3;
    localparam int SYM_W = 2;
    localparam int CNT_W = 8;
    localparam int DEPTH = 32;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic clk = 1'b0;
    logic reset;

    fsm_table_ctrl_if #(.ST_W(ST_W), .SYM_W(SYM_W), .CNT_W(CNT_W)) bus ();

    fsm_table_ctrl #(.ST_W(ST_W), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       due;
        bit [2:0] val;
    } exp_t;

    exp_t     q[$];
    bit [5:0] m_tbl [DEPTH];
    bit [5:0] tbl_src [DEPTH];
    bit [31:0] m_wr;
    int       m_mode;
    bit [2:0] m_st;
    bit [2:0] m_saida;
    int       m_cnt;
    int       cyc;
    int       pulses;
    int       checks;
    int       errors;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_st    = '0;
        m_saida = '0;
        m_cnt   = 0;
        m_wr    = '0;
        q.delete();
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_edge();
        bit       allw;
        bit [4:0] ad;
        bit [5:0] e;
        cyc++;
        case (m_mode)
            M_IDLE: begin
                allw = &m_wr;
                if (bus.cfg_we) begin
                    m_tbl[bus.cfg_addr] = bus.cfg_data;
                    m_wr[bus.cfg_addr]  = 1'b1;
                end
                if (bus.start) begin
                    if (allw) begin
                        m_mode = M_RUN;
                        m_st   = '0;
                        m_cnt  = 0;
                    end else begin
                        m_mode = M_ERR;
                    end
                end
            end
            M_RUN: begin
                if (bus.stop) begin
                    m_mode = M_IDLE;
                    m_st   = '0;
                end else begin
                    if (bus.sym_valid) begin
                        ad      = {m_st, bus.sym};
                        e       = m_tbl[ad];
                        m_st    = e[5:3];
                        m_saida = e[2:0];
                        if (m_cnt < 255) m_cnt++;
                        q.push_back('{cyc, e[2:0]});
                    end
                    if (bus.cfg_we) m_mode = M_ERR;
                end
            end
            default: begin
                if (bus.stop) begin
                    m_mode = M_IDLE;
                    m_wr   = '0;
                end
            end
        endcase
    endtask

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check("sym_ready", int'(bus.sym_ready), int'(m_mode == M_RUN && !bus.stop));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic load(input int skip);
        for (int a = 0; a < DEPTH; a++) begin
            if (a != skip) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 5'(a);
                bus.cfg_data = tbl_src[a];
                tick();
            end
        end
        bus.cfg_we = 1'b0;
    endtask

    // Monitor: pops expected pulses and checks registered outputs each cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            check("saida_valid_pulse", int'(bus.saida_valid), 1);
            check("saida_pulse", int'(bus.saida), int'(q[0].val));
            void'(q.pop_front());
            pulses++;
        end else begin
            check("saida_valid_quiet", int'(bus.saida_valid), 0);
        end
        check("mode", int'(bus.mode), m_mode);
        check("sym_cnt", int'(bus.sym_cnt), m_cnt);
        check("saida_hold", int'(bus.saida), int'(m_saida));
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        pulses = 0;
        reset  = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.sym_valid = 1'b0; bus.sym = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) tbl_src[i] = 6'($urandom);
        tbl_src[0] = 6'h09;

        repeat (2) @(negedge clk);
        check("reset_mode", int'(bus.mode), M_IDLE);
        check("reset_saida_valid", int'(bus.saida_valid), 0);
        check("reset_cnt", int'(bus.sym_cnt), 0);
        reset = 1'b1;

        // Incomplete table: start must fault, stop must clear the mask.
        load(17);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("incomplete_err", int'(bus.mode), M_ERR);
        bus.sym_valid = 1'b1; tick(); bus.sym_valid = 1'b0;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("err_to_idle", int'(bus.mode), M_IDLE);
        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd17; bus.cfg_data = tbl_src[17]; tick();
        bus.cfg_we = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("mask_cleared_err", int'(bus.mode), M_ERR);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;

        // Full table, entry0 = 6'h09, symbol 0.
        load(-1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.sym_valid = 1'b1; bus.sym = 2'd0; tick(); bus.sym_valid = 1'b0;
        check("first_saida", int'(bus.saida), 1);
        check("first_valid", int'(bus.saida_valid), 1);
        check("first_state", int'(dut.state_q), 1);
        tick();

        // Random traffic with stop/start requests; mask stays full.
        for (int i = 0; i < 400; i++) begin
            bus.sym_valid = ($urandom_range(9) < 7);
            bus.sym       = 2'($urandom);
            bus.stop      = ($urandom_range(19) == 0);
            bus.start     = ($urandom_range(19) == 1);
            tick();
        end
        bus.sym_valid = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;

        // 300 back-to-back symbols from a fresh start; counter saturates.
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        p0 = pulses;
        bus.sym_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.sym = 2'($urandom);
            tick();
        end
        bus.sym_valid = 1'b0;
        check("cnt_saturated", int'(bus.sym_cnt), 255);
        tick();
        check("pulse_count_300", pulses - p0, 300);

        // stop together with start and a symbol: stop wins.
        bus.stop = 1'b1; bus.start = 1'b1; bus.sym_valid = 1'b1; tick();
        bus.stop = 1'b0; bus.start = 1'b0; bus.sym_valid = 1'b0;
        check("stop_wins_idle", int'(bus.mode), M_IDLE);
        tick();

        // Write attempt in RUN: entry untouched, ERR entered.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd2; bus.cfg_data = ~tbl_src[2]; tick();
        bus.cfg_we = 1'b0;
        check("run_write_err", int'(bus.mode), M_ERR);
        check("run_write_mem", int'(dut.u_table.mem_q[2]), int'(tbl_src[2]));
        bus.sym_valid = 1'b1; tick(); bus.sym_valid = 1'b0;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        load(-1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.sym_valid = 1'b1; bus.sym = 2'd2; tick(); bus.sym_valid = 1'b0;
        check("readback_saida", int'(bus.saida), int'(tbl_src[2][2:0]));
        check("readback_state", int'(dut.state_q), int'(tbl_src[2][5:3]));
        tick();

        // Asynchronous reset between edges aborts the pending pulse.
        bus.sym_valid = 1'b1; bus.sym = 2'($urandom);
        #1;
        check("pre_reset_ready", int'(bus.sym_ready), 1);
        @(posedge clk);
        model_edge();
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", int'(bus.saida_valid), 0);
        check("areset_saida", int'(bus.saida), 0);
        check("areset_mode", int'(bus.mode), M_IDLE);
        check("areset_cnt", int'(bus.sym_cnt), 0);
        check("areset_ready", int'(bus.sym_ready), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.sym_valid = 1'b0;
        tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("post_reset_mask_err", int'(bus.mode), M_ERR);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_table_ctrl.md
FSM_TABLE_CTRL -- requirements
Module: fsm_table_ctrl

Interface
REQ-001 Parameter ST_W, default 3, width of the sequenced machine's state and output.
REQ-002 Parameter SYM_W, default 2, width of one input symbol.
REQ-003 Parameter CNT_W, default 8, width of the accepted-symbol counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  table write strobe.
REQ-007 cfg_addr  in  ST_W+SYM_W  table entry index, {state,symbol}.
REQ-008 cfg_data  in  2*ST_W  entry contents, {next_state,output}.
REQ-009 start  in  1  one-cycle request to enter RUN.
REQ-010 stop  in  1  one-cycle request to leave RUN.
REQ-011 sym_valid  in  1  symbol offered.
REQ-012 sym  in  SYM_W  input symbol.
REQ-013 sym_ready  out  1  symbol accepted this cycle when high with sym_valid.
REQ-014 saida  out  ST_W  output of the last accepted symbol's table entry.
REQ-015 saida_valid  out  1  one-cycle pulse, saida updated.
REQ-016 mode  out  2  controller state: IDLE=00, RUN=01, ERR=10.
REQ-017 sym_cnt  out  CNT_W  accepted symbols since last start, saturating.

Function
REQ-018 The block SHALL hold a 2^(ST_W+SYM_W) x 2*ST_W table (32x6 at defaults), synchronous write, asynchronous read.
REQ-019 IDLE: cfg_we SHALL write cfg_data to cfg_addr at the clock edge and set that entry's bit in a written mask.
REQ-020 IDLE + start with all mask bits set SHALL go to RUN next cycle, clear machine state to 0 and clear sym_cnt.
REQ-021 IDLE + start with any mask bit clear SHALL go to ERR; the table is unchanged.
REQ-022 sym_ready SHALL equal (mode==RUN) && !stop, combinationally.
REQ-023 On an accepted symbol, the entry at address {state,sym} SHALL be read; state <= entry[2*ST_W-1:ST_W], saida <= entry[ST_W-1:0], saida_valid=1 the next cycle (latency 1).
REQ-024 Back-to-back symbols SHALL be accepted every cycle; each uses the state produced by the previous one.
REQ-025 sym_cnt SHALL increment per accepted symbol and saturate at 2^CNT_W-1, with no wrap.
REQ-026 RUN + stop SHALL return to IDLE next cycle; state resets to 0; saida holds its value; the mask is retained.
REQ-027 stop together with start or sym_valid: stop wins; no symbol is accepted.
REQ-028 start in RUN and stop in IDLE SHALL be ignored.
REQ-029 cfg_we in RUN SHALL NOT write the table and SHALL move to ERR (sym_ready low from the next cycle).
REQ-030 ERR SHALL be left only by stop, which goes to IDLE and clears the mask (the table must be reloaded).
REQ-031 saida_valid SHALL be 0 in every cycle without an acceptance in the preceding cycle.

Reset
REQ-032 Reset low SHALL immediately force mode=IDLE, state=0, saida=0, saida_valid=0, sym_cnt=0 and mask=0; table contents are undefined.
REQ-033 Reset asserted mid-RUN SHALL abort any pending acceptance; no saida_valid pulse follows.

Structure
REQ-034 Mode encodings and the default widths SHALL live in the shared package fsm_pkg.
REQ-035 The table SHALL be a sub-module fsm_table (write port, asynchronous read port); the controller, counter and mask stay in fsm_table_ctrl.

Verification
REQ-036 Load all 32 entries, entry0=6'h09, then start and sym=0 -> next cycle saida=1, saida_valid=1, state=1.
REQ-037 Load only 31 entries, then start -> mode=ERR, sym_ready=0; then stop -> mode=IDLE with the mask cleared.
REQ-038 RUN with sym_valid held for 300 cycles -> 300 consecutive saida_valid pulses; sym_cnt=255.
REQ-039 RUN with stop and sym_valid in the same cycle -> sym_ready=0, no pulse, and mode=IDLE next cycle.
REQ-040 cfg_we in RUN -> table entry unchanged (read back after stop/reload) and mode=ERR.
REQ-041 Reset asserted between clock edges during RUN -> all outputs 0 immediately and mode=IDLE.
